// File: rtl/checker_auto.sv
// checker_auto: CHECKER_MODE_AUTO unit. Runs the MPU once per enabled program
// slot (a sweep), waits a programmable period between sweeps, repeats for a
// given sweep count or until stopped, then reports a status word with an IRQ.
// Optional per-slot watchdog: define CHECKER_AUTO_TIMEOUT_EN.
module checker_auto #(
  parameter logic [1:0] mode    = 2'd2,
  parameter int         NSLOT   = 4,
  parameter int         SLOT_W  = 2,
  parameter int         TIMEOUT = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        mode_mode,
  input  logic              mode_start,
  input  logic              mode_stop,
  input  logic [63:0]       mode_addr,
  output logic              mode_end,
  output logic [63:0]       mode_data,
  output logic              mode_irq,
  input  logic              mode_ack,
  output logic              mpu_en,
  output logic              mpu_rst,
  output logic [SLOT_W-1:0] mpu_slot,
  input  logic              mpu_error,
  input  logic [63:0]       mpu_user_data,
  input  logic              mpu_user_irq
);

  typedef enum logic [2:0] {IDLE, RST, RUN, WAIT, REPORT} state_t;

  state_t            state;
  logic [31:0]       period;
  logic [23:0]       count;
  logic [23:0]       sweeps;
  logic [NSLOT-1:0]  mask;
  logic [31:0]       wait_cnt;
  logic [31:0]       user_data;
  logic              err;
  logic              tmo;
  logic              stopped;

  // Lowest set bit of m at or above index 'from'; returns {found, index}.
  function automatic logic [SLOT_W:0] find_slot(input logic [NSLOT-1:0] m, input int from);
    logic              found;
    logic [SLOT_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        found = 1'b1;
        idx   = SLOT_W'(i);
      end
    end
    return {found, idx};
  endfunction

  // Host-visible status layout.
  function automatic logic [63:0] status_word(input logic e, input logic t, input logic s,
                                              input logic [SLOT_W-1:0] slot,
                                              input logic [23:0] sw, input logic [31:0] ud);
    logic [2:0] slot3;
    slot3 = 3'(slot);
    return {e, t, s, 2'b00, slot3, sw, ud};
  endfunction

  logic [NSLOT-1:0]  start_mask;
  logic              start_found, first_found, next_found;
  logic [SLOT_W-1:0] start_idx, first_idx, next_idx;
  logic [23:0]       sweeps_inc, sweeps_nxt;
  logic [31:0]       ud_nxt;
  logic              run_done, sweep_end, count_hit, timeout_hit;
  logic              rpt_err, rpt_tmo, rpt_stop, rpt_go;
  logic              unused_bits;

  // Slot bits at or above NSLOT are ignored.
  assign start_mask = mode_addr[56 +: NSLOT];

  // Upper halves not carried into the status word.
  assign unused_bits = ^{mode_addr[63:56], mpu_user_data[63:32], first_found};

`ifdef CHECKER_AUTO_TIMEOUT_EN
  logic [31:0] wdog;

  // Per-slot watchdog: held at zero outside RUN, so it restarts on every RUN entry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || (state != RUN)) wdog <= '0;
    else                           wdog <= wdog + 32'd1;
  end

  assign timeout_hit = (state == RUN) && !mpu_error && !mpu_user_irq &&
                       (wdog >= 32'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Slot selection, sweep accounting and report decisions for the current cycle.
  always_comb begin
    {start_found, start_idx} = find_slot(start_mask, 0);
    {first_found, first_idx} = find_slot(mask, 0);
    {next_found, next_idx}   = find_slot(mask, int'(mpu_slot) + 1);
    sweeps_inc = (&sweeps) ? sweeps : sweeps + 24'd1;
    run_done   = (state == RUN) && mpu_user_irq && !mpu_error;
    sweep_end  = run_done && !next_found;
    sweeps_nxt = sweep_end ? sweeps_inc : sweeps;
    ud_nxt     = run_done ? mpu_user_data[31:0] : user_data;
    count_hit  = sweep_end && (count != '0) && (sweeps_inc == count);
    rpt_err    = (state == RUN) && mpu_error;
    rpt_stop   = mode_stop && (((state == RUN) && !mpu_error) || (state == WAIT));
    rpt_tmo    = timeout_hit;
    rpt_go     = rpt_err | rpt_stop | rpt_tmo | count_hit;
  end

  // Scheduler state machine with registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      period    <= '0;
      count     <= '0;
      sweeps    <= '0;
      mask      <= '0;
      wait_cnt  <= '0;
      user_data <= '0;
      err       <= 1'b0;
      tmo       <= 1'b0;
      stopped   <= 1'b0;
      mode_end  <= 1'b0;
      mode_irq  <= 1'b0;
      mode_data <= '0;
      mpu_en    <= 1'b0;
      mpu_rst   <= 1'b0;
      mpu_slot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mode_start && (mode_mode == mode)) begin
            period    <= mode_addr[31:0];
            count     <= mode_addr[55:32];
            mask      <= start_mask;
            sweeps    <= '0;
            user_data <= '0;
            err       <= 1'b0;
            tmo       <= 1'b0;
            stopped   <= 1'b0;
            if (!start_found) begin
              state    <= REPORT;
              mpu_slot <= '0;
            end else begin
              state    <= RST;
              mpu_slot <= start_idx;
              mpu_rst  <= 1'b1;
            end
          end
        end
        RST: begin
          state   <= RUN;
          mpu_rst <= 1'b0;
          mpu_en  <= 1'b1;
        end
        RUN, WAIT: begin
          sweeps    <= sweeps_nxt;
          user_data <= ud_nxt;
          if (rpt_go) begin
            state     <= REPORT;
            err       <= rpt_err;
            tmo       <= rpt_tmo;
            stopped   <= rpt_stop;
            mpu_en    <= 1'b0;
            mpu_rst   <= 1'b0;
            mode_end  <= 1'b1;
            mode_irq  <= 1'b1;
            mode_data <= status_word(rpt_err, rpt_tmo, rpt_stop, mpu_slot, sweeps_nxt, ud_nxt);
          end else if (state == RUN) begin
            if (run_done && next_found) begin
              state    <= RST;
              mpu_slot <= next_idx;
              mpu_rst  <= 1'b1;
              mpu_en   <= 1'b0;
            end else if (run_done) begin
              state    <= WAIT;
              wait_cnt <= period;
              mpu_en   <= 1'b0;
            end
          end else begin
            // Period P gives P idle cycles; a zero period still idles one cycle.
            if (wait_cnt <= 32'd1) begin
              state    <= RST;
              mpu_slot <= first_idx;
              mpu_rst  <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - 32'd1;
            end
          end
        end
        REPORT: begin
          if (mode_ack) begin
            state     <= IDLE;
            mode_end  <= 1'b0;
            mode_irq  <= 1'b0;
            mode_data <= '0;
            mpu_en    <= 1'b0;
            mpu_rst   <= 1'b0;
            mpu_slot  <= '0;
          end else begin
            mode_end  <= 1'b1;
            mode_irq  <= 1'b1;
            mode_data <= status_word(err, tmo, stopped, mpu_slot, sweeps, user_data);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
